i2c_master_core: RTL and testbench

//   I2C master that drives register transactions to i2c_core slaves on the shared SCL/SDA bus.

---
 rtl/i2c_master_core.sv | 270 +++++++++++++++++++++++++++
 tb/tb_i2c_master_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_core.sv
// I2C register-access master: one command (device, register, 0-3 bytes, read or write)
// becomes one write frame, or a pointer frame followed by a data frame for reads.
// Every bit is four quarters of CLK_DIV clocks; SCL is low in Q0-Q1 and high in Q2-Q3.
module i2c_master_core #(
   parameter int CLK_DIV = 8
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_start,
   input  logic        I_rw,
   input  logic [6:0]  I_devaddr,
   input  logic [7:0]  I_regaddr,
   input  logic [1:0]  I_nbytes,
   input  logic [23:0] I_wdata,
   output logic [23:0] O_rdata,
   output logic        O_busy,
   output logic        O_done,
   output logic        O_nack,
   input  logic        I_scl,
   output logic        OE_scl,
   input  logic        I_sda,
   output logic        O_sda,
   output logic        OE_sda
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_START     = 4'd1;
   localparam logic [3:0] S_ADDR      = 4'd2;
   localparam logic [3:0] S_ADDR_ACK  = 4'd3;
   localparam logic [3:0] S_REG       = 4'd4;
   localparam logic [3:0] S_REG_ACK   = 4'd5;
   localparam logic [3:0] S_WDATA     = 4'd6;
   localparam logic [3:0] S_WDATA_ACK = 4'd7;
   localparam logic [3:0] S_RDATA     = 4'd8;
   localparam logic [3:0] S_RDATA_ACK = 4'd9;
   localparam logic [3:0] S_STOP      = 4'd10;

   logic [3:0]    state_q, state_d;
   logic [CW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    quarter_q, quarter_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [1:0]    left_q, left_d;
   logic          dphase_q, dphase_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          nack_q, nack_d;
   logic [23:0]   rdata_q, rdata_d;
   logic          oe_scl_q, oe_scl_d;
   logic          oe_sda_q, oe_sda_d;
   logic [7:0]    tx_q, tx_d;
   logic          smp_q, smp_d;
   logic          rw_q;
   logic [6:0]    dev_q;
   logic [7:0]    reg_q;
   logic [23:0]   wdata_q;
   logic          accept, qend, bend;

   // Write bytes go out most significant first: n bytes remaining selects byte n-1.
   function automatic logic [7:0] pick_byte(input logic [23:0] w, input logic [1:0] n);
      case (n)
         2'd3:    return w[23:16];
         2'd2:    return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   assign accept = I_start && !busy_q;
   assign qend   = (qcnt_q == CW'(CLK_DIV - 1));
   assign bend   = qend && (quarter_q == 2'd3);

   // Quarter timing, bit/byte sequencing and frame control.
   always_comb begin
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      quarter_d = quarter_q;
      bitcnt_d  = bitcnt_q;
      left_d    = left_q;
      dphase_d  = dphase_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      nack_d    = nack_q;
      rdata_d   = rdata_q;
      tx_d      = tx_q;
      smp_d     = smp_q;
      if (state_q == S_IDLE) begin
         qcnt_d    = '0;
         quarter_d = 2'd0;
         if (accept) begin
            state_d  = S_START;
            busy_d   = 1'b1;
            nack_d   = 1'b0;
            dphase_d = 1'b0;
            left_d   = I_nbytes;
         end
      end else begin
         if (qend) begin
            qcnt_d    = '0;
            quarter_d = quarter_q + 2'd1;
         end else begin
            qcnt_d = qcnt_q + 1'b1;
         end
         if (qend && (quarter_q == 2'd2)) smp_d = I_sda;
         if (bend) begin
            case (state_q)
               S_START: begin
                  state_d  = S_ADDR;
                  tx_d     = {dev_q, dphase_q};
                  bitcnt_d = 3'd0;
               end
               S_ADDR, S_REG, S_WDATA, S_RDATA: begin
                  if (state_q == S_RDATA) rdata_d = {rdata_q[22:0], smp_q};
                  if (bitcnt_q == 3'd7) begin
                     bitcnt_d = 3'd0;
                     case (state_q)
                        S_ADDR:  state_d = S_ADDR_ACK;
                        S_REG:   state_d = S_REG_ACK;
                        S_WDATA: state_d = S_WDATA_ACK;
                        default: state_d = S_RDATA_ACK;
                     endcase
                  end else begin
                     bitcnt_d = bitcnt_q + 3'd1;
                     tx_d     = {tx_q[6:0], 1'b0};
                  end
               end
               S_ADDR_ACK: begin
                  if (smp_q) begin
                     state_d = S_STOP;
                     nack_d  = 1'b1;
                  end else if (dphase_q) begin
                     state_d = S_RDATA;
                  end else begin
                     state_d = S_REG;
                     tx_d    = reg_q;
                  end
               end
               S_REG_ACK: begin
                  if (smp_q) begin
                     state_d = S_STOP;
                     nack_d  = 1'b1;
                  end else if (!rw_q && (left_q != 2'd0)) begin
                     state_d = S_WDATA;
                     tx_d    = pick_byte(wdata_q, left_q);
                  end else begin
                     state_d = S_STOP;
                  end
               end
               S_WDATA_ACK: begin
                  if (smp_q) begin
                     state_d = S_STOP;
                     nack_d  = 1'b1;
                  end else begin
                     left_d = left_q - 2'd1;
                     if (left_q != 2'd1) begin
                        state_d = S_WDATA;
                        tx_d    = pick_byte(wdata_q, left_q - 2'd1);
                     end else begin
                        state_d = S_STOP;
                     end
                  end
               end
               S_RDATA_ACK: begin
                  left_d  = left_q - 2'd1;
                  state_d = (left_q != 2'd1) ? S_RDATA : S_STOP;
               end
               default: begin
                  // End of STOP: a clean read pointer frame chains into the data frame.
                  if (!nack_q && rw_q && !dphase_q && (left_q != 2'd0)) begin
                     state_d  = S_START;
                     dphase_d = 1'b1;
                     rdata_d  = '0;
                  end else begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // Pin drive decoded from the next state so the open-drain enables come straight from flops.
   always_comb begin
      oe_scl_d = 1'b0;
      oe_sda_d = 1'b0;
      case (state_d)
         S_IDLE: begin
            oe_scl_d = 1'b0;
            oe_sda_d = 1'b0;
         end
         S_START: begin
            oe_scl_d = (quarter_d == 2'd3);
            oe_sda_d = (quarter_d != 2'd0);
         end
         S_STOP: begin
            oe_scl_d = (quarter_d == 2'd0);
            oe_sda_d = (quarter_d != 2'd3);
         end
         S_ADDR, S_REG, S_WDATA: begin
            oe_scl_d = !quarter_d[1];
            oe_sda_d = !tx_d[7];
         end
         S_RDATA_ACK: begin
            oe_scl_d = !quarter_d[1];
            oe_sda_d = (left_d != 2'd1);
         end
         default: begin
            oe_scl_d = !quarter_d[1];
            oe_sda_d = 1'b0;
         end
      endcase
   end

   // Control state and bus enables; reset releases the bus at once without a STOP.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q   <= S_IDLE;
         qcnt_q    <= '0;
         quarter_q <= 2'd0;
         bitcnt_q  <= 3'd0;
         left_q    <= 2'd0;
         dphase_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         nack_q    <= 1'b0;
         rdata_q   <= '0;
         oe_scl_q  <= 1'b0;
         oe_sda_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         quarter_q <= quarter_d;
         bitcnt_q  <= bitcnt_d;
         left_q    <= left_d;
         dphase_q  <= dphase_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         nack_q    <= nack_d;
         rdata_q   <= rdata_d;
         oe_scl_q  <= oe_scl_d;
         oe_sda_q  <= oe_sda_d;
      end
   end

   // Command capture, transmit shifter and SDA sample; no reset needed on these.
   always_ff @(posedge I_clk) begin
      tx_q  <= tx_d;
      smp_q <= smp_d;
      if (accept) begin
         rw_q    <= I_rw;
         dev_q   <= I_devaddr;
         reg_q   <= I_regaddr;
         wdata_q <= I_wdata;
      end
   end

   // Slaves never stretch, so a pulled-low SCL must always read back low.
   a_scl_follows : assert property (@(posedge I_clk) disable iff (I_rst) OE_scl |-> !I_scl);

   assign O_rdata = rdata_q;
   assign O_busy  = busy_q;
   assign O_done  = done_q;
   assign O_nack  = nack_q;
   assign OE_scl  = oe_scl_q;
   assign OE_sda  = oe_sda_q;
   assign O_sda   = 1'b0;

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: behavioural I2C register slave at 0x1C on the bus,
// scoreboard of expected completions drained by a monitor on O_done.
module tb_i2c_master_core;

   localparam int CLK_DIV = 8;

   typedef struct {
      logic [23:0] rd;
      logic        nk;
      int          t0;
      int          len;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        rw = 1'b0;
   logic [6:0]  dev = '0;
   logic [7:0]  ra = '0;
   logic [1:0]  nb = '0;
   logic [23:0] wd = '0;
   logic [23:0] rdata;
   logic        busy, done, nack, oe_scl, o_sda, oe_sda;
   logic        slv_pull = 1'b0;
   wire         scl_w = ~oe_scl;
   wire         sda_w = ~(oe_sda | slv_pull);

   int   n_assert = 0;
   int   n_fail = 0;
   int   cyc = 0;
   exp_t sb[$];
   exp_t mon_e;

   // slave model state
   logic [7:0] mem [256];
   logic [7:0] bus_log[$];
   logic       mack[$];
   int         bus_bytes = 0;

   i2c_master_core #(.CLK_DIV(CLK_DIV)) dut (
      .I_clk(clk), .I_rst(rst), .I_start(start), .I_rw(rw),
      .I_devaddr(dev), .I_regaddr(ra), .I_nbytes(nb), .I_wdata(wd),
      .O_rdata(rdata), .O_busy(busy), .O_done(done), .O_nack(nack),
      .I_scl(scl_w), .OE_scl(oe_scl), .I_sda(sda_w), .O_sda(o_sda), .OE_sda(oe_sda)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int fl(input int k);
      return CLK_DIV * (8 + 36 * k);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every O_done is matched against the oldest expected completion.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("rdata", {8'h00, rdata}, {8'h00, mon_e.rd});
            chk("nack", {31'd0, nack}, {31'd0, mon_e.nk});
            chk("latency", cyc - mon_e.t0, mon_e.len + 1);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            chk("o_sda", {31'd0, o_sda}, 32'd0);
         end
      end
   end

   // Behavioural slave at 0x1C with auto-incrementing register pointer.
   initial begin
      logic       pscl, psda, c, s, active, rxm, addressed, rdm;
      logic [7:0] sh, txb, ptr;
      int         bit_i, byte_no;
      pscl = 1'b1; psda = 1'b1; active = 1'b0; rxm = 1'b1; addressed = 1'b0; rdm = 1'b0;
      sh = '0; txb = '0; ptr = '0; bit_i = 0; byte_no = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      forever begin
         @(negedge clk);
         c = scl_w;
         s = sda_w;
         if (pscl && c && psda && !s) begin
            active = 1'b1; rxm = 1'b1; addressed = 1'b0; bit_i = 0; byte_no = 0; slv_pull = 1'b0;
         end else if (pscl && c && !psda && s) begin
            active = 1'b0; slv_pull = 1'b0;
         end else if (active && !pscl && c) begin
            if (bit_i < 8) begin
               if (rxm) sh = {sh[6:0], s};
               bit_i++;
               if (bit_i == 8 && rxm) begin
                  bus_bytes++;
                  bus_log.push_back(sh);
                  if (byte_no == 0) begin
                     addressed = (sh[7:1] == 7'h1C);
                     rdm = sh[0];
                  end else if (addressed) begin
                     if (byte_no == 1) ptr = sh;
                     else begin mem[ptr] = sh; ptr++; end
                  end
               end
            end else begin
               bit_i = 0;
               if (rxm) begin
                  if (byte_no == 0 && addressed && rdm) begin
                     rxm = 1'b0; txb = mem[ptr]; ptr++;
                  end
                  byte_no++;
               end else begin
                  mack.push_back(s);
                  if (!s) begin txb = mem[ptr]; ptr++; byte_no++; end
                  else active = 1'b0;
               end
            end
         end else if (active && pscl && !c) begin
            if (bit_i == 8) slv_pull = rxm && addressed;
            else slv_pull = rxm ? 1'b0 : !txb[7 - bit_i];
         end
         pscl = c;
         psda = s;
      end
   end

   task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] a, input logic [1:0] n,
                        input logic [23:0] w, input logic [23:0] erd, input logic enk, input int elen);
      exp_t e;
      @(posedge clk); #1;
      rw = r; dev = d; ra = a; nb = n; wd = w; start = 1'b1;
      e.rd = erd; e.nk = enk; e.t0 = cyc; e.len = elen;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_rise", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) begin
         n_assert++;
         n_fail++;
         $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, m0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_nack", {31'd0, nack}, 32'd0);
      chk("rst_rdata", {8'h00, rdata}, 32'd0);
      chk("rst_oe_scl", {31'd0, oe_scl}, 32'd0);
      chk("rst_oe_sda", {31'd0, oe_sda}, 32'd0);
      rst = 1'b0;

      // 1: single-byte write to CREG
      issue(1'b0, 7'h1C, 8'h00, 2'd1, 24'h0000A5, 24'h000000, 1'b0, fl(3));
      wait_idle("t1");
      chk("t1_creg", {24'd0, mem[0]}, 32'hA5);

      // 2: single-byte read back, master NACKs the only byte
      m0 = mack.size();
      issue(1'b1, 7'h1C, 8'h00, 2'd1, 24'h0, 24'h0000A5, 1'b0, fl(2) + fl(2));
      wait_idle("t2");
      chk("t2_acks", mack.size() - m0, 1);
      if (mack.size() > m0) chk("t2_nack_last", {31'd0, mack[m0]}, 32'd1);

      // 3: three-byte write to DLY then read back
      issue(1'b0, 7'h1C, 8'h03, 2'd3, 24'h123456, 24'h0000A5, 1'b0, fl(5));
      wait_idle("t3w");
      chk("t3_dly", {8'h00, mem[3], mem[4], mem[5]}, 32'h123456);
      m0 = mack.size();
      issue(1'b1, 7'h1C, 8'h03, 2'd3, 24'h0, 24'h123456, 1'b0, fl(2) + fl(4));
      wait_idle("t3r");
      chk("t3_acks", mack.size() - m0, 3);
      if (mack.size() >= m0 + 3) begin
         chk("t3_ack1", {31'd0, mack[m0]}, 32'd0);
         chk("t3_ack2", {31'd0, mack[m0+1]}, 32'd0);
         chk("t3_ack3", {31'd0, mack[m0+2]}, 32'd1);
      end

      // 4: absent slave NACKs the address byte
      b0 = bus_bytes;
      issue(1'b0, 7'h2C, 8'h00, 2'd1, 24'h000011, 24'h123456, 1'b1, CLK_DIV * 44);
      wait_idle("t4");
      chk("t4_bytes", bus_bytes - b0, 1);
      chk("t4_addr_byte", {24'd0, bus_log[bus_log.size()-1]}, 32'h58);
      chk("t4_creg", {24'd0, mem[0]}, 32'hA5);

      // 5: second start mid-frame is ignored
      b0 = bus_bytes;
      issue(1'b0, 7'h1C, 8'h00, 2'd1, 24'h00003C, 24'h123456, 1'b0, fl(3));
      repeat (100) @(posedge clk);
      #1;
      rw = 1'b0; dev = 7'h1C; ra = 8'h03; nb = 2'd3; wd = 24'hFFFFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("t5");
      chk("t5_creg", {24'd0, mem[0]}, 32'h3C);
      chk("t5_dly", {8'h00, mem[3], mem[4], mem[5]}, 32'h123456);
      chk("t5_bytes", bus_bytes - b0, 3);

      // 6: reset during the REG byte, then a clean write
      @(posedge clk); #1;
      rw = 1'b0; dev = 7'h1C; ra = 8'h00; nb = 2'd1; wd = 24'h000077; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (338) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6_oe_sda", {31'd0, oe_sda}, 32'd0);
      chk("t6_oe_scl", {31'd0, oe_scl}, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_rdata", {8'h00, rdata}, 32'd0);
      rst = 1'b0;
      chk("t6_creg_kept", {24'd0, mem[0]}, 32'h3C);
      issue(1'b0, 7'h1C, 8'h00, 2'd1, 24'h00005A, 24'h000000, 1'b0, fl(3));
      wait_idle("t6");
      chk("t6_creg", {24'd0, mem[0]}, 32'h5A);

      repeat (5) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
